regfile_wb_arbiter: RTL

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter.sv | 100 ++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: merges load and ALU writebacks onto one register-file write port.
// Latency: one cycle from handshake to registered rf_* outputs; one write per cycle sustained.
// Backpressure: losing requester sees ready=0 and holds; rd=0 requests always accepted; no output backpressure.
// Optional feature: define WB_AGING_EN to let a starved ALU request win after STARVE_LIMIT lost cycles.
module regfile_wb_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld_valid,
    input  logic [4:0]  ld_rd,
    input  logic [31:0] ld_data,
    output logic        ld_ready,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    output logic        rf_w_en,
    output logic [4:0]  rf_rd,
    output logic [31:0] rf_write_data,
    output logic        rf_src
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    // Requests that actually need the write port (rd=0 writes are discarded)
    logic ld_req;
    logic alu_req;
    logic alu_prio;
    logic ld_grant;
    logic alu_grant;

    assign ld_req  = ld_valid  && (ld_rd  != 5'd0);
    assign alu_req = alu_valid && (alu_rd != 5'd0);

`ifdef WB_AGING_EN
    logic [3:0] age_cnt;
    logic [3:0] age_cnt_inc;
    logic       age_force;

    assign age_cnt_inc = (age_cnt == 4'hF) ? age_cnt : age_cnt + 4'd1;
    assign alu_prio    = age_force;

    // Count ALU cycles lost to the load; once the limit is hit the ALU takes the next contested slot
    always_ff @(posedge clk) begin
        if (rst) begin
            age_cnt   <= 4'd0;
            age_force <= 1'b0;
        end else if (alu_valid && alu_ready) begin
            age_cnt   <= 4'd0;
            age_force <= 1'b0;
        end else if (alu_req && !alu_ready) begin
            age_cnt   <= age_cnt_inc;
            age_force <= age_force || (age_cnt_inc == LIMIT);
        end
    end
`else
    // Strict load priority; the limit only matters when aging is built in
    logic unused_limit;
    assign unused_limit = ^LIMIT;
    assign alu_prio     = 1'b0;
`endif

    // Single write slot: load wins unless the ALU has been starved
    always_comb begin
        ld_grant  = 1'b0;
        alu_grant = 1'b0;
        if (alu_req && (!ld_req || alu_prio)) begin
            alu_grant = 1'b1;
        end else if (ld_req) begin
            ld_grant = 1'b1;
        end
    end

    // rd=0 requests are swallowed without using the slot; nothing is accepted during reset
    assign ld_ready  = !rst && ((ld_rd  == 5'd0) || ld_grant);
    assign alu_ready = !rst && ((alu_rd == 5'd0) || alu_grant);

    // Register the granted write; address/data/source hold when idle
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_w_en       <= 1'b0;
            rf_rd         <= 5'd0;
            rf_write_data <= 32'd0;
            rf_src        <= 1'b0;
        end else begin
            rf_w_en <= ld_grant || alu_grant;
            if (ld_grant) begin
                rf_rd         <= ld_rd;
                rf_write_data <= ld_data;
                rf_src        <= 1'b1;
            end else if (alu_grant) begin
                rf_rd         <= alu_rd;
                rf_write_data <= alu_data;
                rf_src        <= 1'b0;
            end
        end
    end

endmodule
